// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared definitions for the I2C command sequencer: field widths, command
// packing order and FSM state encoding.
`timescale 1ns/1ps
package i2c_cmd_sequencer_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int CMD_W  = 16;   // packed as {rw, addr, data}

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_STOP = 2'd2,
      ST_GAP       = 2'd3
   } seq_state_t;

   // Pack one command into its FIFO word.
   function automatic logic [CMD_W-1:0] pack_cmd(
      input logic              rw,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      return {rw, addr, data};
   endfunction

   // Largest of three counts, used to size the shared timeout/gap counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_bus_monitor.sv
// Bus observer: synchronises SCL/SDA into the clk domain and flags bus START
// and STOP conditions as one-cycle registered pulses. Usable on the slave side too.
`timescale 1ns/1ps
module i2c_cmd_sequencer_bus_monitor (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_scl_in,
   input  logic i_sda_in,
   output logic o_bus_start,
   output logic o_bus_stop
);

   // [0] first sync stage, [1] synchronised value, [2] previous synchronised value
   logic [2:0] r_scl_pipe;
   logic [2:0] r_sda_pipe;
   logic       r_bus_start;
   logic       r_bus_stop;
   logic       w_scl_high;
   logic       w_start_cond;
   logic       w_stop_cond;

   // SCL must be high on both the previous and current synchronised samples
   assign w_scl_high   = r_scl_pipe[2] & r_scl_pipe[1];
   assign w_start_cond = w_scl_high &  r_sda_pipe[2] & ~r_sda_pipe[1];
   assign w_stop_cond  = w_scl_high & ~r_sda_pipe[2] &  r_sda_pipe[1];

   // Synchroniser chains (reset to idle-bus high) and registered event pulses
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_scl_pipe  <= 3'b111;
         r_sda_pipe  <= 3'b111;
         r_bus_start <= 1'b0;
         r_bus_stop  <= 1'b0;
      end else begin
         r_scl_pipe  <= {r_scl_pipe[1:0], i_scl_in};
         r_sda_pipe  <= {r_sda_pipe[1:0], i_sda_in};
         r_bus_start <= w_start_cond;
         r_bus_stop  <= w_stop_cond;
      end
   end

   assign o_bus_start = r_bus_start;
   assign o_bus_stop  = r_bus_stop;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: queues write/read commands and presents them one at
// a time to an I2C master, tracking each transaction from bus START to STOP,
// with start/transaction timeouts and an enforced bus-free gap afterwards.
`timescale 1ns/1ps
module i2c_cmd_sequencer
   import i2c_cmd_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int START_TIMEOUT = 5000,
   parameter int TXN_TIMEOUT   = 100000,
   parameter int BUF_CYCLES    = 250
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [ADDR_W-1:0]             i_cmd_addr,
   input  logic [DATA_W-1:0]             i_cmd_data,
   input  logic                          i_cmd_rw,
   output logic                          o_start,
   output logic [ADDR_W-1:0]             o_addr,
   output logic [DATA_W-1:0]             o_data,
   output logic                          o_rw,
   input  logic                          i_scl_in,
   input  logic                          i_sda_in,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_timeout,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int CNT_MAX = max3(START_TIMEOUT, TXN_TIMEOUT, BUF_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Command FIFO
   logic [CMD_W-1:0] r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_next;
   logic             r_cmd_ready;
   logic             w_push;
   logic             w_pop;
   logic [CMD_W-1:0] w_head;

   // Sequencer state
   seq_state_t       r_state;
   seq_state_t       w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_start;
   logic             w_start_next;
   logic             r_done;
   logic             w_done_next;
   logic             r_timeout;
   logic             w_timeout_next;
   logic             r_busy;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_rw;

   logic w_bus_start;
   logic w_bus_stop;

   i2c_cmd_sequencer_bus_monitor u_bus_monitor (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_scl_in    (i_scl_in),
      .i_sda_in    (i_sda_in),
      .o_bus_start (w_bus_start),
      .o_bus_stop  (w_bus_stop)
   );

   assign w_push = i_cmd_valid & r_cmd_ready;
   assign w_head = r_fifo[r_rd_ptr];

   // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
   always_comb begin
      w_level_next = r_level;
      if (w_push && !w_pop) begin
         w_level_next = r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
         w_level_next = r_level - LVL_W'(1);
      end else begin
         w_level_next = r_level;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= pack_cmd(i_cmd_rw, i_cmd_addr, i_cmd_data);
      end
   end

   // FIFO pointers, occupancy and ready flag
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr    <= {PTR_W{1'b0}};
         r_rd_ptr    <= {PTR_W{1'b0}};
         r_level     <= {LVL_W{1'b0}};
         r_cmd_ready <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_level     <= w_level_next;
         r_cmd_ready <= (w_level_next != LVL_W'(FIFO_DEPTH));
      end
   end

   // Next-state, counter and pulse logic of the transaction sequencer
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt + CNT_W'(1);
      w_start_next   = r_start;
      w_done_next    = 1'b0;
      w_timeout_next = 1'b0;
      w_pop          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_next = {CNT_W{1'b0}};
            if (r_level != {LVL_W{1'b0}}) begin
               w_pop        = 1'b1;
               w_start_next = 1'b1;
               w_state_next = ST_ISSUE;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (w_bus_start) begin
               w_start_next = 1'b0;
               w_cnt_next   = {CNT_W{1'b0}};
               w_state_next = ST_WAIT_STOP;
            end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
               w_start_next   = 1'b0;
               w_timeout_next = 1'b1;
               w_cnt_next     = {CNT_W{1'b0}};
               w_state_next   = ST_GAP;
            end else begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_WAIT_STOP: begin
            // A repeated START keeps the transaction open, so only STOP ends it
            if (w_bus_stop) begin
               w_done_next  = 1'b1;
               w_cnt_next   = {CNT_W{1'b0}};
               w_state_next = ST_GAP;
            end else if (r_cnt == CNT_W'(TXN_TIMEOUT - 1)) begin
               w_timeout_next = 1'b1;
               w_cnt_next     = {CNT_W{1'b0}};
               w_state_next   = ST_GAP;
            end else begin
               w_state_next = ST_WAIT_STOP;
            end
         end
         ST_GAP: begin
            // Another master starting on the bus restarts the bus-free interval
            if (w_bus_start) begin
               w_cnt_next   = {CNT_W{1'b0}};
               w_state_next = ST_GAP;
            end else if (r_cnt == CNT_W'(BUF_CYCLES - 1)) begin
               w_cnt_next   = {CNT_W{1'b0}};
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_GAP;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = {CNT_W{1'b0}};
            w_start_next = 1'b0;
         end
      endcase
   end

   // Sequencer registers and registered master-facing outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= {CNT_W{1'b0}};
         r_start   <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
         r_addr    <= {ADDR_W{1'b0}};
         r_data    <= {DATA_W{1'b0}};
         r_rw      <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_start   <= w_start_next;
         r_done    <= w_done_next;
         r_timeout <= w_timeout_next;
         r_busy    <= (w_state_next != ST_IDLE);
         if (w_pop) begin
            r_rw   <= w_head[CMD_W-1];
            r_addr <= w_head[CMD_W-2 -: ADDR_W];
            r_data <= w_head[DATA_W-1:0];
         end
      end
   end

   assign o_cmd_ready = r_cmd_ready;
   assign o_level     = r_level;
   assign o_start     = r_start;
   assign o_addr      = r_addr;
   assign o_data      = r_data;
   assign o_rw        = r_rw;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_timeout   = r_timeout;

endmodule
